sample_frame_ctrl: RTL and testbench

SAMPLE_FRAME_CTRL -- requirements
Module: sample_frame_ctrl

---
 rtl/sample_pkg.sv | 19 +
 rtl/sample_frame_ctrl_if.sv | 40 ++++
 rtl/decim_counter.sv | 30 +++
 rtl/sample_frame_ctrl.sv | 122 ++++++++++++
 tb/tb_sample_frame_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/sample_pkg.sv
// Shared definitions for the sample frame controller: FSM encoding and size defaults.
package sample_pkg;

  localparam int DEPTH_DEF = 64;
  localparam int WIDTH_DEF = 11;
  localparam int DECIM_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic logic is_busy(state_t s);
    return (s == ST_ARMED) || (s == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/sample_frame_ctrl_if.sv
// Control, sample-input and slot-bank write signals of the sample frame controller.
interface sample_frame_ctrl_if #(
  parameter int DEPTH = sample_pkg::DEPTH_DEF,
  parameter int WIDTH = sample_pkg::WIDTH_DEF
);
  import sample_pkg::*;

  localparam int IW = $clog2(DEPTH);

  logic               start;
  logic               abort;
  logic               cont;
  logic               trig_en;
  logic [WIDTH-1:0]   trig_level;
  logic [DECIM_W-1:0] decim;
  logic [WIDTH-1:0]   sample_in;
  logic               sample_valid;

  // Handshakes: sample_valid qualifies sample_in for one cycle and wr_en
  // qualifies wr_data/wr_index for one cycle. Neither has a ready: the
  // controller and the slot bank always accept, so a beat is never stalled.
  logic [WIDTH-1:0]   wr_data;
  logic [IW-1:0]      wr_index;
  logic               wr_en;
  logic               busy;
  logic               frame_done;
  logic [7:0]         frame_count;
  state_t             dbg_state;

  modport master (
    output start, abort, cont, trig_en, trig_level, decim, sample_in, sample_valid,
    input  wr_data, wr_index, wr_en, busy, frame_done, frame_count, dbg_state
  );

  modport slave (
    input  start, abort, cont, trig_en, trig_level, decim, sample_in, sample_valid,
    output wr_data, wr_index, wr_en, busy, frame_done, frame_count, dbg_state
  );

endinterface

// File: rtl/decim_counter.sv
// Modulo-(limit+1) counter of valid samples; zero marks the sample to keep.
module decim_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         zero
);

  logic [W-1:0] count;

  // clear+inc together is the triggering sample: it is count 0, so the
  // counter moves straight on to 1 (or stays at 0 when nothing is skipped).
  // Wrapping on >= keeps the counter sane if limit shrinks mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= (inc && (limit != '0)) ? W'(1) : '0;
    end else if (inc) begin
      count <= (count >= limit) ? '0 : count + 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sample_frame_ctrl.sv
// Sample frame controller: arms on start, triggers, decimates and writes one
// frame of DEPTH samples into an external slot bank.
module sample_frame_ctrl
  import sample_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input logic               clk,
  input logic               rst,
  sample_frame_ctrl_if.slave bus
);

  localparam int            IW       = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  state_t           state, state_nxt;
  logic [IW-1:0]    wr_ptr;
  logic [IW-1:0]    write_idx;
  logic             accept;
  logic             last_write;
  logic             frame_inc;
  logic             trig_ok;
  logic             dc_clear;
  logic             dc_inc;
  logic             dc_zero;

  logic [WIDTH-1:0] wr_data_q;
  logic [IW-1:0]    wr_index_q;
  logic             wr_en_q;
  logic             frame_done_q;
  logic [7:0]       frame_count_q;

  decim_counter #(.W(DECIM_W)) u_decim (
    .clk   (clk),
    .rst   (rst),
    .clear (dc_clear),
    .inc   (dc_inc),
    .limit (bus.decim),
    .zero  (dc_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // The triggering sample always lands in slot 0, so the pointer left over
  // from a previous or aborted frame never needs an explicit clear.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    dc_clear   = 1'b0;
    dc_inc     = 1'b0;
    frame_inc  = 1'b0;
    trig_ok    = !bus.trig_en || (bus.sample_in >= bus.trig_level);
    write_idx  = (state == ST_ARMED) ? '0 : wr_ptr;
    last_write = (write_idx == LAST_IDX);
    if (bus.abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) state_nxt = ST_ARMED;
        end
        ST_ARMED: begin
          if (bus.sample_valid && trig_ok) begin
            accept    = 1'b1;
            dc_clear  = 1'b1;
            dc_inc    = 1'b1;
            state_nxt = last_write ? ST_DONE : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (bus.sample_valid) begin
            dc_inc = 1'b1;
            if (dc_zero) begin
              accept = 1'b1;
              if (last_write) state_nxt = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          frame_inc = 1'b1;
          state_nxt = bus.cont ? ST_ARMED : ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // wr_data/wr_index only move on an accepted sample, so a slot bank clocked
  // every cycle just rewrites the same slot with the same value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_data_q     <= '0;
      wr_index_q    <= '0;
      wr_en_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      wr_ptr        <= '0;
    end else begin
      wr_en_q      <= accept;
      frame_done_q <= accept && last_write;
      if (accept) begin
        wr_data_q  <= bus.sample_in;
        wr_index_q <= write_idx;
        wr_ptr     <= write_idx + 1'b1;
      end
      if (frame_inc) frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign bus.wr_data     = wr_data_q;
  assign bus.wr_index    = wr_index_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_count = frame_count_q;
  assign bus.busy        = is_busy(state);
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_sample_frame_ctrl.sv
// Scoreboard bench for sample_frame_ctrl: directed frames with hand-computed writes.
module tb_sample_frame_ctrl;
  import sample_pkg::*;

  localparam int DEPTH = 64;
  localparam int WIDTH = 11;
  localparam int IW    = 6;
  localparam int W     = 1 + IW + WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sample_frame_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  sample_frame_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // expected write: {frame_done, wr_index, wr_data}
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(int data, int idx, bit fd);
    exp_q.push_back({fd, IW'(idx), WIDTH'(data)});
  endtask

  // apply inputs, let one rising edge sample them, return 1 time unit after it
  task automatic step(bit v, int d);
    bus.sample_valid = v;
    bus.sample_in    = WIDTH'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step(1'b0, 0);
    bus.start = 1'b0;
  endtask

  // monitor: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: index %0d data %0d frame_done %0b, expected no write",
                   bus.wr_index, bus.wr_data, bus.frame_done);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("wr_data", int'(bus.wr_data), int'(e[WIDTH-1:0]));
          check("wr_index", int'(bus.wr_index), int'(e[WIDTH+IW-1:WIDTH]));
          check("frame_done", int'(bus.frame_done), int'(e[W-1]));
        end
      end else if (bus.frame_done) begin
        checks++;
        errors++;
        $display("FAIL stray_frame_done: got 1 without wr_en, expected 0");
      end
    end
  end

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.cont         = 1'b0;
    bus.trig_en      = 1'b0;
    bus.trig_level   = '0;
    bus.decim        = '0;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_wr_en", int'(bus.wr_en), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_frame_done", int'(bus.frame_done), 0);
    check("reset_frame_count", int'(bus.frame_count), 0);
    check("reset_wr_index", int'(bus.wr_index), 0);
    check("reset_state", int'(bus.dbg_state), int'(ST_IDLE));
    rst = 1'b0;
    step(1'b0, 0);

    // basic frame: 64 samples 0..63, every one written
    pulse_start();
    check("t1_busy_armed", int'(bus.busy), 1);
    for (int k = 0; k < DEPTH; k++) push_exp(k, k, k == DEPTH - 1);
    for (int k = 0; k < DEPTH; k++) step(1'b1, k);
    check("t1_busy_in_done", int'(bus.busy), 0);
    step(1'b0, 0);
    check("t1_frame_count", int'(bus.frame_count), 1);
    check("t1_state_idle", int'(bus.dbg_state), int'(ST_IDLE));

    // decimation by 3: samples 0..191 keep 0,3,...,189
    bus.decim = 4'd2;
    pulse_start();
    for (int k = 0; k < DEPTH; k++) push_exp(3 * k, k, k == DEPTH - 1);
    for (int k = 0; k < 192; k++) step(1'b1, k);
    step(1'b0, 0);
    check("t2_frame_count", int'(bus.frame_count), 2);
    check("t2_busy", int'(bus.busy), 0);

    // level trigger at 500 on a ramp 490..600: writes 500..563
    bus.decim      = 4'd0;
    bus.trig_en    = 1'b1;
    bus.trig_level = WIDTH'(500);
    pulse_start();
    for (int k = 0; k < DEPTH; k++) push_exp(500 + k, k, k == DEPTH - 1);
    for (int v = 490; v <= 600; v++) step(1'b1, v);
    step(1'b0, 0);
    check("t3_frame_count", int'(bus.frame_count), 3);
    check("t3_hold_wr_data", int'(bus.wr_data), 563);
    check("t3_hold_wr_index", int'(bus.wr_index), 63);

    // abort on the sample after ten writes (indices 0..9): that write is dropped
    bus.trig_en = 1'b0;
    pulse_start();
    for (int k = 0; k < 10; k++) push_exp(k, k, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, k);
    bus.abort = 1'b1;
    step(1'b1, 10);
    bus.abort = 1'b0;
    check("t4_state_idle", int'(bus.dbg_state), int'(ST_IDLE));
    check("t4_busy", int'(bus.busy), 0);
    step(1'b0, 0);
    check("t4_wr_en", int'(bus.wr_en), 0);
    check("t4_wr_index", int'(bus.wr_index), 9);
    check("t4_wr_data", int'(bus.wr_data), 9);
    check("t4_frame_count", int'(bus.frame_count), 3);

    // continuous mode: two frames, re-armed without a new start
    bus.cont = 1'b1;
    pulse_start();
    for (int k = 0; k < DEPTH; k++) push_exp(k, k, k == DEPTH - 1);
    for (int k = 0; k < DEPTH; k++) push_exp(100 + k, k, k == DEPTH - 1);
    for (int k = 0; k < DEPTH; k++) step(1'b1, k);
    check("t5_busy_done1", int'(bus.busy), 0);
    step(1'b0, 0);
    check("t5_busy_rearmed", int'(bus.busy), 1);
    check("t5_count_mid", int'(bus.frame_count), 4);
    step(1'b0, 0);
    for (int k = 0; k < DEPTH; k++) step(1'b1, 100 + k);
    check("t5_busy_done2", int'(bus.busy), 0);
    bus.cont = 1'b0;
    step(1'b0, 0);
    check("t5_frame_count", int'(bus.frame_count), 5);
    check("t5_state_idle", int'(bus.dbg_state), int'(ST_IDLE));

    // asynchronous reset between edges in the middle of a capture
    pulse_start();
    for (int k = 0; k < 20; k++) push_exp(k, k, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, k);
    step(1'b0, 0);
    check("t6_busy_before", int'(bus.busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_wr_data", int'(bus.wr_data), 0);
    check("t6_wr_index", int'(bus.wr_index), 0);
    check("t6_wr_en", int'(bus.wr_en), 0);
    check("t6_busy", int'(bus.busy), 0);
    check("t6_frame_done", int'(bus.frame_done), 0);
    check("t6_frame_count", int'(bus.frame_count), 0);
    check("t6_state", int'(bus.dbg_state), int'(ST_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 70; k++) step(1'b1, k);
    check("t6_count_after", int'(bus.frame_count), 0);
    check("t6_state_after", int'(bus.dbg_state), int'(ST_IDLE));

    repeat (3) step(1'b0, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
